// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative Booth multiply
// and restoring signed divide, with registered results and a done pulse.
module seq_alu #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [SIG_COUNT-1:0] ctrl_signal,
  input  logic [BITS-1:0]      X,
  input  logic [BITS-1:0]      Y,
  output logic [BITS-1:0]      OpResult_HI,
  output logic [BITS-1:0]      OpResult_LO,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CW  = $clog2(BITS + 1);
  localparam int SHW = $clog2(BITS);

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_ROR = 6;
  localparam int OP_ROL = 7;
  localparam int OP_AND = 8;
  localparam int OP_OR  = 9;
  localparam int OP_NEG = 10;
  localparam int OP_NOT = 11;

  localparam logic [CW-1:0]        CNT_LAST = CW'(BITS);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
  localparam logic [SHW:0]         SH_FULL  = (SHW+1)'(BITS);
  localparam logic [BITS-1:0]      ZERO_W   = {BITS{1'b0}};
  localparam logic [BITS-1:0]      ONES_W   = {BITS{1'b1}};
  localparam logic [SIG_COUNT-1:0] OP_ZERO  = {SIG_COUNT{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_MUL    = 2'd2,
    ST_DIV    = 2'd3
  } state_t;

  function automatic logic is_onehot(input logic [SIG_COUNT-1:0] v);
    is_onehot = (v != OP_ZERO) &&
                ((v & (v - {{(SIG_COUNT-1){1'b0}}, 1'b1})) == OP_ZERO);
  endfunction

  function automatic logic [BITS-1:0] negate(input logic [BITS-1:0] v);
    negate = ~v + {{(BITS-1){1'b0}}, 1'b1};
  endfunction

  // Most-negative input maps to 2^(BITS-1), which still fits unsigned in BITS bits.
  function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
    magnitude = v[BITS-1] ? negate(v) : v;
  endfunction

  state_t                 state_q, state_d;
  logic [SIG_COUNT-1:0]   op_q, op_d;
  logic [BITS-1:0]        x_q, x_d, y_q, y_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2*BITS+1:0]      prod_q, prod_d;
  logic [BITS:0]          rem_q, rem_d;
  logic [BITS-1:0]        quo_q, quo_d;
  logic [BITS-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                   err_q, err_d, done_q, done_d, busy_q, busy_d;

  logic [SHW-1:0]  sh;
  logic [SHW:0]    rot_amt;
  logic [BITS:0]   booth_m, booth_acc, booth_sum;
  logic [BITS+1:0] div_shift, div_diff;
  logic            div_ge, q_neg;

  assign sh        = y_q[SHW-1:0];
  assign rot_amt   = SH_FULL - {1'b0, sh};
  assign booth_m   = {x_q[BITS-1], x_q};
  assign booth_acc = prod_q[2*BITS+1:BITS+1];
  assign div_shift = {rem_q, quo_q[BITS-1]};
  assign div_diff  = div_shift - {2'b00, magnitude(y_q)};
  assign div_ge    = ~div_diff[BITS+1];
  assign q_neg     = x_q[BITS-1] ^ y_q[BITS-1];

  // Booth recoding of the multiplier pair {Q[0], q-1}
  always_comb begin
    booth_sum = booth_acc;
    case (prod_q[1:0])
      2'b01:   booth_sum = booth_acc + booth_m;
      2'b10:   booth_sum = booth_acc - booth_m;
      default: booth_sum = booth_acc;
    endcase
  end

  // Next-state, datapath and result computation
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = ctrl_signal;
          x_d    = X;
          y_d    = Y;
          cnt_d  = CNT_ZERO;
          prod_d = {{(BITS+1){1'b0}}, Y, 1'b0};
          rem_d  = {(BITS+1){1'b0}};
          quo_d  = magnitude(X);
          if (is_onehot(ctrl_signal) && ctrl_signal[OP_MUL]) begin
            state_d = ST_MUL;
          end else if (is_onehot(ctrl_signal) && ctrl_signal[OP_DIV]) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_SINGLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SINGLE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        hi_d    = ZERO_W;
        lo_d    = ZERO_W;
        err_d   = 1'b0;
        if (!is_onehot(op_q))  err_d = 1'b1;
        else if (op_q[OP_ADD]) lo_d = x_q + y_q;
        else if (op_q[OP_SUB]) lo_d = x_q - y_q;
        else if (op_q[OP_SHR]) lo_d = x_q >> sh;
        else if (op_q[OP_SHL]) lo_d = x_q << sh;
        else if (op_q[OP_ROR]) lo_d = (x_q >> sh) | (x_q << rot_amt);
        else if (op_q[OP_ROL]) lo_d = (x_q << sh) | (x_q >> rot_amt);
        else if (op_q[OP_AND]) lo_d = x_q & y_q;
        else if (op_q[OP_OR])  lo_d = x_q | y_q;
        else if (op_q[OP_NEG]) lo_d = negate(y_q);
        else if (op_q[OP_NOT]) lo_d = ~y_q;
        else                   err_d = 1'b1;
      end

      ST_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          hi_d    = prod_q[2*BITS:BITS+1];
          lo_d    = prod_q[BITS:1];
          err_d   = 1'b0;
        end else begin
          prod_d = {booth_sum[BITS], booth_sum, prod_q[BITS:1]};
          cnt_d  = cnt_q + CNT_ONE;
        end
      end

      ST_DIV: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (y_q == ZERO_W) begin
            err_d = 1'b1;
            lo_d  = ONES_W;
            hi_d  = x_q;
          end else begin
            err_d = 1'b0;
            lo_d  = q_neg ? negate(quo_q) : quo_q;
            hi_d  = x_q[BITS-1] ? negate(rem_q[BITS-1:0]) : rem_q[BITS-1:0];
          end
        end else begin
          rem_d = div_ge ? div_diff[BITS:0] : div_shift[BITS:0];
          quo_d = {quo_q[BITS-2:0], div_ge};
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and result registers; clr overrides any pending start or iteration
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ZERO;
      x_q     <= ZERO_W;
      y_q     <= ZERO_W;
      cnt_q   <= CNT_ZERO;
      prod_q  <= {(2*BITS+2){1'b0}};
      rem_q   <= {(BITS+1){1'b0}};
      quo_q   <= ZERO_W;
      hi_q    <= ZERO_W;
      lo_q    <= ZERO_W;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign OpResult_HI = hi_q;
  assign OpResult_LO = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
